// File: rtl/scan_keypad_pkg.sv
// Shared types for the keypad scanner: matrix geometry, frame classes,
// FSM states and the frame classification helper.
package scan_keypad_pkg;

    localparam int KP_ROWS = 4;
    localparam int KP_COLS = 4;
    localparam int KP_KEYS = KP_ROWS * KP_COLS;

    typedef enum logic [1:0] {
        NONE   = 2'd0,
        SINGLE = 2'd1,
        MULTI  = 2'd2
    } frame_class_e;

    typedef enum logic {
        IDLE    = 1'b0,
        PRESSED = 1'b1
    } kp_state_e;

    typedef struct packed {
        frame_class_e cls;
        logic [3:0]   code;
    } frame_t;

    // Code is forced to zero unless exactly one key is seen, so NONE and MULTI
    // frames always compare equal to their own kind in the debouncer.
    function automatic frame_t classify_frame(input logic [KP_KEYS-1:0] snap);
        frame_t      res;
        logic [3:0]  last_idx;
        int unsigned cnt;
        cnt      = 32'd0;
        last_idx = 4'h0;
        for (int i = 0; i < KP_KEYS; i++) begin
            if (snap[i]) begin
                cnt      = cnt + 32'd1;
                last_idx = 4'(i);
            end else begin
                cnt      = cnt;
            end
        end
        case (cnt)
            32'd0: begin
                res.cls  = NONE;
                res.code = 4'h0;
            end
            32'd1: begin
                res.cls  = SINGLE;
                res.code = last_idx;
            end
            default: begin
                res.cls  = MULTI;
                res.code = 4'h0;
            end
        endcase
        return res;
    endfunction

endpackage

// File: rtl/scan_keypad_debounce.sv
// Frame-level debouncer: counts consecutive identical frames and flags the
// frame that reaches (or stays at) the required run length.
module keypad_debounce
    import scan_keypad_pkg::*;
#(
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         frame_stb_i,
    input  frame_class_e frame_class_i,
    input  logic [3:0]   frame_code_i,
    output logic         stable_stb_o,
    output frame_class_e stable_class_o,
    output logic [3:0]   stable_code_o
);

    localparam int              CNT_W   = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_SCANS);

    logic [CNT_W-1:0] match_cnt_q, match_cnt_d;
    frame_class_e     prev_class_q, prev_class_d;
    logic [3:0]       prev_code_q, prev_code_d;

    // Match counter and previous-frame next-state
    always_comb begin
        match_cnt_d  = match_cnt_q;
        prev_class_d = prev_class_q;
        prev_code_d  = prev_code_q;
        if (frame_stb_i) begin
            prev_class_d = frame_class_i;
            prev_code_d  = frame_code_i;
            if ((frame_class_i == prev_class_q) && (frame_code_i == prev_code_q)) begin
                if (match_cnt_q == CNT_MAX) begin
                    match_cnt_d = CNT_MAX;
                end else begin
                    match_cnt_d = match_cnt_q + CNT_W'(1);
                end
            end else begin
                match_cnt_d = CNT_W'(1);
            end
        end else begin
            match_cnt_d = match_cnt_q;
        end
    end

    // Debounce state registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            match_cnt_q  <= {CNT_W{1'b0}};
            prev_class_q <= NONE;
            prev_code_q  <= 4'h0;
        end else begin
            match_cnt_q  <= match_cnt_d;
            prev_class_q <= prev_class_d;
            prev_code_q  <= prev_code_d;
        end
    end

    assign stable_stb_o   = frame_stb_i && (match_cnt_d == CNT_MAX);
    assign stable_class_o = frame_class_i;
    assign stable_code_o  = frame_code_i;

endmodule

// File: rtl/scan_keypad.sv
// 4x4 active-low keypad scanner: row drive, column synchronizer, frame
// snapshot and press/release FSM around the frame debouncer.
module scan_keypad
    import scan_keypad_pkg::*;
#(
    parameter int SCAN_PERIOD    = 20000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [KP_COLS-1:0] col_in,
    output logic [KP_ROWS-1:0] row_out,
    output logic               key_valid,
    output logic [3:0]         key_code,
    output logic               key_down
);

    localparam int                TICK_W    = (SCAN_PERIOD > 1) ? $clog2(SCAN_PERIOD) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SCAN_PERIOD - 1);
    localparam int                ROW_W     = $clog2(KP_ROWS);
    localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(KP_ROWS - 1);

    logic [KP_COLS-1:0] col_meta_q, col_sync_q;
    logic [TICK_W-1:0]  tick_cnt_q, tick_cnt_d;
    logic [ROW_W-1:0]   row_idx_q, row_idx_d;
    logic [KP_ROWS-1:0] row_out_q, row_out_d;
    logic [KP_KEYS-1:0] snap_q, snap_d;
    logic               tick_s;
    logic               frame_stb_s;
    frame_t             frame_s;
    logic               stable_stb_s;
    frame_class_e       stable_class_s;
    logic [3:0]         stable_code_s;
    kp_state_e          state_q, state_d;
    logic               key_valid_q, key_valid_d;
    logic [3:0]         key_code_q, key_code_d;
    logic               key_down_q, key_down_d;

    assign tick_s      = (tick_cnt_q == TICK_LAST);
    assign frame_stb_s = tick_s && (row_idx_q == ROW_LAST);
    // Row 3 lands in snap_d on this same edge, so classify the updated copy.
    assign frame_s     = classify_frame(snap_d);

    // Column synchronizer; idle columns read high through the pull-ups
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            col_meta_q <= 4'hF;
            col_sync_q <= 4'hF;
        end else begin
            col_meta_q <= col_in;
            col_sync_q <= col_meta_q;
        end
    end

    // Tick counter, row advance and snapshot capture
    always_comb begin
        tick_cnt_d = tick_cnt_q;
        row_idx_d  = row_idx_q;
        snap_d     = snap_q;
        if (tick_s) begin
            tick_cnt_d = {TICK_W{1'b0}};
            if (row_idx_q == ROW_LAST) begin
                row_idx_d = {ROW_W{1'b0}};
            end else begin
                row_idx_d = row_idx_q + ROW_W'(1);
            end
            for (int r = 0; r < KP_ROWS; r++) begin
                if (row_idx_q == ROW_W'(r)) begin
                    snap_d[r*KP_COLS +: KP_COLS] = ~col_sync_q;
                end else begin
                    snap_d[r*KP_COLS +: KP_COLS] = snap_q[r*KP_COLS +: KP_COLS];
                end
            end
        end else begin
            tick_cnt_d = tick_cnt_q + TICK_W'(1);
        end
        row_out_d = ~(4'b0001 << row_idx_d);
    end

    // Scan datapath registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tick_cnt_q <= {TICK_W{1'b0}};
            row_idx_q  <= {ROW_W{1'b0}};
            row_out_q  <= 4'b1110;
            snap_q     <= {KP_KEYS{1'b0}};
        end else begin
            tick_cnt_q <= tick_cnt_d;
            row_idx_q  <= row_idx_d;
            row_out_q  <= row_out_d;
            snap_q     <= snap_d;
        end
    end

    keypad_debounce #(
        .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
    ) u_debounce (
        .clk            (clk),
        .rstn           (rstn),
        .frame_stb_i    (frame_stb_s),
        .frame_class_i  (frame_s.cls),
        .frame_code_i   (frame_s.code),
        .stable_stb_o   (stable_stb_s),
        .stable_class_o (stable_class_s),
        .stable_code_o  (stable_code_s)
    );

    // Press/release FSM; a different key while pressed needs a release first
    always_comb begin
        state_d     = state_q;
        key_code_d  = key_code_q;
        key_down_d  = key_down_q;
        key_valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (stable_stb_s && (stable_class_s == SINGLE)) begin
                    key_code_d  = stable_code_s;
                    key_valid_d = 1'b1;
                    key_down_d  = 1'b1;
                    state_d     = PRESSED;
                end else begin
                    state_d     = IDLE;
                end
            end
            PRESSED: begin
                if (stable_stb_s && (stable_class_s == NONE)) begin
                    key_down_d = 1'b0;
                    state_d    = IDLE;
                end else begin
                    state_d    = PRESSED;
                end
            end
            default: begin
                key_down_d = 1'b0;
                state_d    = IDLE;
            end
        endcase
    end

    // FSM and output registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            key_valid_q <= 1'b0;
            key_code_q  <= 4'h0;
            key_down_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            key_valid_q <= key_valid_d;
            key_code_q  <= key_code_d;
            key_down_q  <= key_down_d;
        end
    end

    assign row_out   = row_out_q;
    assign key_valid = key_valid_q;
    assign key_code  = key_code_q;
    assign key_down  = key_down_q;

endmodule

// File: tb/tb_scan_keypad.sv
// Directed bench for scan_keypad with a 16-cycle frame (SCAN_PERIOD=4,
// DEBOUNCE_SCANS=2) and a resistive-short keypad model.
module tb_scan_keypad;

    logic        clk = 1'b0;
    logic        rstn;
    logic [3:0]  col_in;
    logic [3:0]  row_out;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        key_down;
    logic [15:0] keys_held;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc;
    int          n_pulses;
    int          last_pulse_cyc;
    logic [3:0]  last_pulse_code;
    logic [3:0]  exp_row;

    always #5 clk = ~clk;

    scan_keypad #(
        .SCAN_PERIOD    (4),
        .DEBOUNCE_SCANS (2)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .col_in    (col_in),
        .row_out   (row_out),
        .key_valid (key_valid),
        .key_code  (key_code),
        .key_down  (key_down)
    );

    // Key (r,c) held shorts column c low while row r is driven low
    always_comb begin
        col_in = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keys_held[r*4+c] && !row_out[r]) col_in[c] = 1'b0;
            end
        end
    end

    task automatic step();
        @(negedge clk);
        cyc = cyc + 1;
        if (key_valid === 1'b1) begin
            n_pulses        = n_pulses + 1;
            last_pulse_cyc  = cyc;
            last_pulse_code = key_code;
        end
    endtask

    task automatic run_to(input int target);
        while (cyc < target) step();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        rstn           = 1'b1;
        cyc            = 0;
        n_pulses       = 0;
        last_pulse_cyc = -1;
    endtask

    task automatic test_reset();
        keys_held = 16'h0000;
        @(negedge clk);
        rstn = 1'b0;
        #1;
        n_checks++; if (row_out !== 4'b1110) begin n_fail++; $display("FAIL reset_row_out: got %b expected %b", row_out, 4'b1110); end
        n_checks++; if (key_valid !== 1'b0) begin n_fail++; $display("FAIL reset_key_valid: got %b expected 0", key_valid); end
        n_checks++; if (key_code !== 4'h0) begin n_fail++; $display("FAIL reset_key_code: got %h expected 0", key_code); end
        n_checks++; if (key_down !== 1'b0) begin n_fail++; $display("FAIL reset_key_down: got %b expected 0", key_down); end
        do_reset();
        n_checks++; if (row_out !== 4'b1110) begin n_fail++; $display("FAIL idle_row_c0: got %b expected %b", row_out, 4'b1110); end
        for (int i = 0; i < 64; i++) begin
            step();
            exp_row = ~(4'b0001 << ((cyc / 4) % 4));
            n_checks++; if (row_out !== exp_row) begin n_fail++; $display("FAIL idle_row cyc %0d: got %b expected %b", cyc, row_out, exp_row); end
            n_checks++; if (key_valid !== 1'b0) begin n_fail++; $display("FAIL idle_key_valid cyc %0d: got %b expected 0", cyc, key_valid); end
            n_checks++; if (key_down !== 1'b0) begin n_fail++; $display("FAIL idle_key_down cyc %0d: got %b expected 0", cyc, key_down); end
        end
    endtask

    task automatic test_hold_key();
        keys_held = 16'h0000;
        do_reset();
        keys_held[9] = 1'b1;
        run_to(31);
        n_checks++; if (n_pulses !== 0) begin n_fail++; $display("FAIL hold_early_pulse: got %0d expected 0", n_pulses); end
        run_to(80);
        n_checks++; if (n_pulses !== 1) begin n_fail++; $display("FAIL hold_pulse_count: got %0d expected 1", n_pulses); end
        n_checks++; if (last_pulse_cyc !== 32) begin n_fail++; $display("FAIL hold_pulse_cycle: got %0d expected 32", last_pulse_cyc); end
        n_checks++; if (last_pulse_code !== 4'h9) begin n_fail++; $display("FAIL hold_pulse_code: got %h expected 9", last_pulse_code); end
        n_checks++; if (key_down !== 1'b1) begin n_fail++; $display("FAIL hold_key_down: got %b expected 1", key_down); end
        keys_held = 16'h0000;
        run_to(111);
        n_checks++; if (key_down !== 1'b1) begin n_fail++; $display("FAIL release_early: got %b expected 1", key_down); end
        run_to(112);
        n_checks++; if (key_down !== 1'b0) begin n_fail++; $display("FAIL release_key_down: got %b expected 0", key_down); end
        n_checks++; if (key_code !== 4'h9) begin n_fail++; $display("FAIL release_code_held: got %h expected 9", key_code); end
        run_to(130);
        n_checks++; if (n_pulses !== 1) begin n_fail++; $display("FAIL release_pulse_count: got %0d expected 1", n_pulses); end
    endtask

    task automatic test_bounce();
        keys_held = 16'h0000;
        do_reset();
        for (int t = 0; t < 48; t++) begin
            keys_held[3] = (((t / 3) % 2) == 0);
            step();
        end
        n_checks++; if (n_pulses !== 0) begin n_fail++; $display("FAIL bounce_no_pulse: got %0d expected 0", n_pulses); end
        keys_held[3] = 1'b1;
        run_to(96);
        n_checks++; if (n_pulses !== 1) begin n_fail++; $display("FAIL bounce_pulse_count: got %0d expected 1", n_pulses); end
        n_checks++; if (last_pulse_cyc !== 80) begin n_fail++; $display("FAIL bounce_pulse_cycle: got %0d expected 80", last_pulse_cyc); end
        n_checks++; if (last_pulse_code !== 4'h3) begin n_fail++; $display("FAIL bounce_pulse_code: got %h expected 3", last_pulse_code); end
    endtask

    task automatic test_multi();
        keys_held = 16'h0000;
        do_reset();
        keys_held = 16'h8010;
        run_to(64);
        n_checks++; if (n_pulses !== 0) begin n_fail++; $display("FAIL multi_no_pulse: got %0d expected 0", n_pulses); end
        n_checks++; if (key_down !== 1'b0) begin n_fail++; $display("FAIL multi_key_down: got %b expected 0", key_down); end
        keys_held = 16'h0010;
        run_to(100);
        n_checks++; if (n_pulses !== 1) begin n_fail++; $display("FAIL multi_release_count: got %0d expected 1", n_pulses); end
        n_checks++; if (last_pulse_cyc !== 96) begin n_fail++; $display("FAIL multi_release_cycle: got %0d expected 96", last_pulse_cyc); end
        n_checks++; if (last_pulse_code !== 4'h4) begin n_fail++; $display("FAIL multi_release_code: got %h expected 4", last_pulse_code); end
        keys_held = 16'h8010;
        run_to(160);
        n_checks++; if (n_pulses !== 1) begin n_fail++; $display("FAIL multi_pressed_count: got %0d expected 1", n_pulses); end
        n_checks++; if (key_down !== 1'b1) begin n_fail++; $display("FAIL multi_pressed_down: got %b expected 1", key_down); end
        n_checks++; if (key_code !== 4'h4) begin n_fail++; $display("FAIL multi_pressed_code: got %h expected 4", key_code); end
    endtask

    task automatic test_slide();
        keys_held = 16'h0000;
        do_reset();
        keys_held[5] = 1'b1;
        run_to(48);
        n_checks++; if (n_pulses !== 1) begin n_fail++; $display("FAIL slide_first_count: got %0d expected 1", n_pulses); end
        n_checks++; if (last_pulse_cyc !== 32) begin n_fail++; $display("FAIL slide_first_cycle: got %0d expected 32", last_pulse_cyc); end
        n_checks++; if (last_pulse_code !== 4'h5) begin n_fail++; $display("FAIL slide_first_code: got %h expected 5", last_pulse_code); end
        keys_held = 16'h0040;
        run_to(112);
        n_checks++; if (n_pulses !== 1) begin n_fail++; $display("FAIL slide_pulse_count: got %0d expected 1", n_pulses); end
        n_checks++; if (key_code !== 4'h5) begin n_fail++; $display("FAIL slide_key_code: got %h expected 5", key_code); end
        n_checks++; if (key_down !== 1'b1) begin n_fail++; $display("FAIL slide_key_down: got %b expected 1", key_down); end
    endtask

    task automatic test_reset_midframe();
        keys_held = 16'h0000;
        do_reset();
        keys_held[0] = 1'b1;
        run_to(40);
        n_checks++; if (key_down !== 1'b1) begin n_fail++; $display("FAIL pre_reset_down: got %b expected 1", key_down); end
        n_checks++; if (n_pulses !== 1) begin n_fail++; $display("FAIL pre_reset_count: got %0d expected 1", n_pulses); end
        rstn = 1'b0;
        #1;
        n_checks++; if (row_out !== 4'b1110) begin n_fail++; $display("FAIL midreset_row_out: got %b expected %b", row_out, 4'b1110); end
        n_checks++; if (key_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_key_valid: got %b expected 0", key_valid); end
        n_checks++; if (key_code !== 4'h0) begin n_fail++; $display("FAIL midreset_key_code: got %h expected 0", key_code); end
        n_checks++; if (key_down !== 1'b0) begin n_fail++; $display("FAIL midreset_key_down: got %b expected 0", key_down); end
        repeat (2) @(negedge clk);
        rstn           = 1'b1;
        cyc            = 0;
        n_pulses       = 0;
        last_pulse_cyc = -1;
        run_to(31);
        n_checks++; if (n_pulses !== 0) begin n_fail++; $display("FAIL postreset_early_count: got %0d expected 0", n_pulses); end
        n_checks++; if (key_down !== 1'b0) begin n_fail++; $display("FAIL postreset_early_down: got %b expected 0", key_down); end
        run_to(40);
        n_checks++; if (n_pulses !== 1) begin n_fail++; $display("FAIL postreset_count: got %0d expected 1", n_pulses); end
        n_checks++; if (last_pulse_cyc !== 32) begin n_fail++; $display("FAIL postreset_cycle: got %0d expected 32", last_pulse_cyc); end
        n_checks++; if (last_pulse_code !== 4'h0) begin n_fail++; $display("FAIL postreset_code: got %h expected 0", last_pulse_code); end
        n_checks++; if (key_down !== 1'b1) begin n_fail++; $display("FAIL postreset_down: got %b expected 1", key_down); end
    endtask

    initial begin
        rstn           = 1'b0;
        keys_held      = 16'h0000;
        cyc            = 0;
        n_pulses       = 0;
        last_pulse_cyc = -1;
        test_reset();
        test_hold_key();
        test_bounce();
        test_multi();
        test_slide();
        test_reset_midframe();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
